restoring_div_ctrl: RTL and testbench
=====================================

RESTORING_DIV_CTRL -- requirements
Module: restoring_div_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: operand, quotient and remainder width.
REQ-002 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: request a division; sampled only in IDLE.
REQ-005 Port dividend, input, DATA_W: unsigned dividend; captured when start is accepted.
REQ-006 Port divisor, input, DATA_W: unsigned divisor; captured when start is accepted.
REQ-007 Port busy, output, 1: high in CALC and DONE.
REQ-008 Port done, output, 1: one-cycle pulse marking valid results.
REQ-009 Port quotient, output, DATA_W: result quotient.
REQ-010 Port remainder, output, DATA_W: result remainder.
REQ-011 Port div_by_zero, output, 1: set with done when the captured divisor is 0.

Function
REQ-012 States SHALL be IDLE, CALC and DONE, with no other reachable state.
REQ-013 IDLE with start=1 and divisor!=0 SHALL perform these captures and go to CALC:
- A=0 (DATA_W+1 bits, signed).
- Q=dividend.
- M=divisor.
- cnt=DATA_W-1.
REQ-014 IDLE with start=1 and divisor==0 SHALL perform these updates and go to DONE:
- quotient set to all ones.
- remainder set to dividend.
- div_by_zero set to 1.
REQ-015 Each CALC cycle SHALL perform exactly one restoring iteration, as follows:
- Shift {A,Q} left by 1.
- Compute T=A-M.
- If T is negative (sign bit of T = 1): keep A and write Q[0]=0.
- Otherwise: set A=T and write Q[0]=1.
REQ-016 The sign test SHALL use bit DATA_W of the DATA_W+1-bit difference; an unsigned "<0" compare is forbidden.
REQ-017 CALC SHALL decrement cnt each cycle.
REQ-018 CALC with cnt==0 SHALL do all of the following and go to DONE:
- Load quotient from Q (final iteration included).
- Load remainder from A[DATA_W-1:0].
- Set div_by_zero to 0.
REQ-019 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency SHALL be DATA_W+1 edges after the start-sampling edge for divisor!=0, and 1 edge for divisor==0.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start result overwrites them.
REQ-022 start asserted in CALC or DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 Changes to dividend or divisor after capture SHALL NOT affect the result.
REQ-024 Back-to-back operation: start=1 in the IDLE cycle right after DONE SHALL be accepted.

Reset
REQ-025 rst=1 on a rising edge SHALL force state to IDLE and clear all outputs, A, Q, M and cnt to 0; this includes reset in mid-operation.
REQ-026 When rst and start are both high, rst SHALL win and start SHALL be dropped.

Structure
REQ-027 Package div_pkg SHALL hold the state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the DATA_W default.
REQ-028 The negative-detect on T SHALL be a sub-module sign_test, DATA_W+1 bits wide, with a single output is_neg.
REQ-029 cnt width SHALL be $clog2(DATA_W).

Verification
REQ-030 dividend=100, divisor=7 -> done 33 edges after start; quotient=14, remainder=2, div_by_zero=0.
REQ-031 dividend=3, divisor=10 -> quotient=0, remainder=3; dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 dividend=5, divisor=0 -> done 1 edge after start; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-033 start re-pulsed with 9/2 during CALC of 100/7 -> result stays 14 r 2; exactly one done pulse.
REQ-034 rst=1 for one cycle at iteration 10 of 100/7 -> next cycle state IDLE, all outputs 0; a new start 50/5 -> quotient=10, remainder=0.
REQ-035 0x80000000/0xFFFFFFFF -> quotient=0, remainder=0x80000000; this checks sign-test correctness at the MSB.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider controller.
//   DIV_DATA_W  : default operand / result width
//   div_state_e : controller state encoding (IDLE, CALC, DONE)
package div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/restoring_div_ctrl_sign_test.sv
// Negative detect for the trial subtraction of the restoring divider.
//   value  : W-bit two's complement difference
//   is_neg : 1 when value is negative
module sign_test #(
    parameter int W = 33
) (
    input  logic [W-1:0] value,
    output logic         is_neg
);

    // A signed compare against zero reduces to the MSB (bit W-1) of the
    // difference; it is never an unsigned magnitude compare.
    assign is_neg = $signed(value) < $signed({W{1'b0}});

endmodule

// File: rtl/restoring_div_ctrl.sv
// Multi-cycle unsigned restoring divider, one quotient bit per CALC cycle.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request a division (sampled in IDLE only)
//   dividend, divisor   : unsigned operands, captured on accepted start
//   busy                : high in CALC and DONE
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : set with done when the captured divisor was 0
import div_pkg::*;

module restoring_div_ctrl #(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e state, state_nxt;

    logic [DATA_W:0]   acc;      // partial remainder A, one guard bit
    logic [DATA_W-1:0] q_reg;    // dividend shifting out / quotient shifting in
    logic [DATA_W-1:0] m_reg;    // captured divisor
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W:0]   acc_sh;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   acc_new;
    logic [DATA_W-1:0] q_new;
    logic              diff_neg;

    // {A,Q} << 1: the MSB of Q moves into the LSB of A.
    assign acc_sh = (acc << 1) | {{DATA_W{1'b0}}, q_reg[DATA_W-1]};
    assign diff   = acc_sh - {1'b0, m_reg};

    sign_test #(
        .W(DATA_W + 1)
    ) u_sign_test (
        .value  (diff),
        .is_neg (diff_neg)
    );

    // Restore on negative trial result, otherwise keep the difference.
    assign acc_new = diff_neg ? acc_sh : diff;
    assign q_new   = {q_reg[DATA_W-2:0], ~diff_neg};

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc   <= '0;
                            q_reg <= dividend;
                            m_reg <= divisor;
                            cnt   <= CNT_W'(DATA_W - 1);
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_new;
                    q_reg <= q_new;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Results include this cycle's iteration.
                        quotient    <= q_new;
                        remainder   <= acc_new[DATA_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
module tb_restoring_div_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend, divisor;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient, remainder;

    int n_chk = 0;
    int n_err = 0;

    restoring_div_ctrl #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic division, divide-by-zero convention.
    task automatic ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] q, output logic [DW-1:0] r,
                           output logic z, output int lat);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = DW + 1;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of
    // the IDLE cycle right after DONE, so consecutive calls are back-to-back.
    task automatic do_div(input string tag, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input bit noise);
        logic [DW-1:0] eq, er;
        logic          ez;
        int            elat;
        int            edges;
        int            pulses;
        ref_div(a, b, eq, er, ez, elat);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < DW + 10) begin
            chk({tag, "_busy_calc"}, busy, 1'b1);
            if (noise) begin
                start    = 1'($urandom);
                dividend = $urandom;
                divisor  = $urandom_range(3, 0);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_latency"}, edges, elat);
        chk({tag, "_busy_done"}, busy, 1'b1);
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        pulses = done ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        if (done) pulses++;
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_hold_q"}, quotient, eq);
        chk({tag, "_hold_r"}, remainder, er);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quo", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;

        // Directed cases
        do_div("d100_7", 100, 7, 1'b0);
        do_div("d3_10", 3, 10, 1'b0);
        do_div("dmax_1", 32'hFFFF_FFFF, 1, 1'b0);
        do_div("d5_0", 5, 0, 1'b0);
        do_div("dmsb", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_div("d0_3", 0, 3, 1'b0);

        // Start re-pulsed with 9/2 in CALC must be ignored.
        dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        dividend = 9; divisor = 2; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        begin
            int pulses = 0;
            for (int i = 0; i < 3 * DW; i++) begin
                if (done) begin
                    pulses++;
                    chk("repulse_quo", quotient, 14);
                    chk("repulse_rem", remainder, 2);
                end
                @(posedge clk); @(negedge clk);
            end
            chk("repulse_pulses", pulses, 1);
        end

        // Mid-operation reset, then a fresh division.
        dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_quo", quotient, 0);
        chk("midrst_rem", remainder, 0);
        do_div("d50_5", 50, 5, 1'b0);

        // Reset wins over simultaneous start.
        dividend = 20; divisor = 3; start = 1'b1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        chk("rst_start_quo", quotient, 0);
        @(posedge clk); @(negedge clk);
        chk("rst_start_noqueue", busy, 1'b0);

        // Randomized, with operand/start noise during CALC.
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] a, b;
            a = $urandom;
            case ($urandom_range(3, 0))
                0: b = 0;
                1: b = $urandom_range(15, 1);
                2: b = $urandom >> $urandom_range(31, 0);
                default: b = $urandom;
            endcase
            do_div($sformatf("rnd%0d", i), a, b, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
